// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter feeding a FIFO that is drained
// into a busy-flag-less UART by a fixed-interval pacing FSM.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned CHAR_CYCLES = 4800
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [8*N_REQ-1:0]            req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          tx_en,
    output logic                          uart_we,
    output logic [7:0]                    wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          idle
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned PACE_W = $clog2(CHAR_CYCLES);
    localparam int unsigned RR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Registered state
    logic [RR_W-1:0]   rr_q,      rr_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [LVL_W-1:0]  level_q,   level_d;
    logic [0:0]        state_q,   state_d;
    logic [PACE_W-1:0] pace_q,    pace_d;
    logic              uart_we_q, uart_we_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              idle_q,    idle_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    // Combinational helpers
    logic [7:0]        req_byte [N_REQ];
    logic [N_REQ-1:0]  ready_c;
    logic [RR_W-1:0]   grant_idx;
    logic [RR_W-1:0]   scan_idx;
    int unsigned       scan_sum;
    int unsigned       rr_nxt;
    logic              found;
    logic              push;
    logic              pop;
    logic              empty;
    logic              full;
    logic [7:0]        push_data;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(FIFO_DEPTH));

    // Unpack the flat requester data bus into bytes
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_byte[i] = req_data[8*i +: 8];
        end
    end

    // Round-robin scan from rr upward with wrap; nothing granted when full
    always_comb begin
        ready_c   = '0;
        grant_idx = '0;
        scan_idx  = '0;
        scan_sum  = 0;
        found     = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = int'(rr_q) + k;
            if (scan_sum >= N_REQ) begin
                scan_sum = scan_sum - N_REQ;
            end
            scan_idx = RR_W'(scan_sum);
            if (!found && !full && req_valid[scan_idx]) begin
                ready_c[scan_idx] = 1'b1;
                grant_idx         = scan_idx;
                found             = 1'b1;
            end
        end
    end

    // Grant is suppressed while reset is asserted
    assign req_ready = rst_n ? ready_c : '0;
    assign push      = |(req_valid & req_ready);
    assign push_data = req_byte[grant_idx];

    // Round-robin pointer advances past the granted requester
    always_comb begin
        rr_d   = rr_q;
        rr_nxt = int'(grant_idx) + 1;
        if (rr_nxt >= N_REQ) begin
            rr_nxt = 0;
        end
        if (push) begin
            rr_d = RR_W'(rr_nxt);
        end
    end

    // Issue FSM: one UART write per CHAR_CYCLES clocks while bytes are queued
    always_comb begin
        state_d   = state_q;
        pace_d    = pace_q;
        uart_we_d = 1'b0;
        wr_data_d = wr_data_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && tx_en) begin
                    uart_we_d = 1'b1;
                    wr_data_d = mem_q[rd_ptr_q];
                    pop       = 1'b1;
                    pace_d    = PACE_W'(CHAR_CYCLES - 1);
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pace_q != '0) begin
                    pace_d = pace_q - PACE_W'(1);
                end else if (!empty && tx_en) begin
                    uart_we_d = 1'b1;
                    wr_data_d = mem_q[rd_ptr_q];
                    pop       = 1'b1;
                    pace_d    = PACE_W'(CHAR_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update; push and pop together keep the level
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        idle_d = (state_d == ST_IDLE) && (level_d == '0);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= ST_IDLE;
            pace_q    <= '0;
            uart_we_q <= 1'b0;
            wr_data_q <= 8'h00;
            idle_q    <= 1'b1;
        end else begin
            rr_q      <= rr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            pace_q    <= pace_d;
            uart_we_q <= uart_we_d;
            wr_data_q <= wr_data_d;
            idle_q    <= idle_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign uart_we    = uart_we_q;
    assign wr_data    = wr_data_q;
    assign fifo_level = level_q;
    assign idle       = idle_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with small FIFO and short pacing.
module tb_uart_tx_arbiter;

    localparam int unsigned NR  = 2;
    localparam int unsigned FD  = 4;
    localparam int unsigned CC  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           v0, v1;
    logic [7:0]     d0, d1;
    logic [NR-1:0]  req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic           tx_en;
    logic           uart_we;
    logic [7:0]     wr_data;
    logic [2:0]     fifo_level;
    logic           idle;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int push_cyc;
    int last_wait;
    int peak;
    int p0;
    int kc;

    logic [7:0] pd [$];
    int         pc [$];
    int         glog [$];

    assign req_valid = {v1, v0};
    assign req_data  = {d1, d0};

    uart_tx_arbiter #(.N_REQ(NR), .FIFO_DEPTH(FD), .CHAR_CYCLES(CC)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_en(tx_en), .uart_we(uart_we), .wr_data(wr_data),
        .fifo_level(fifo_level), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] pd_at(input int i);
        return (i < pd.size()) ? pd[i] : 8'hxx;
    endfunction

    function automatic int pc_at(input int i);
        return (i < pc.size()) ? pc[i] : -1;
    endfunction

    function automatic int gl_at(input int i);
        return (i < glog.size()) ? glog[i] : -1;
    endfunction

    // Sample outputs on the falling edge: pulses, grants, peak level, grant legality
    always @(negedge clk) begin
        if (uart_we) begin
            pd.push_back(wr_data);
            pc.push_back(cyc);
        end
        if (v0 && req_ready[0]) glog.push_back(0);
        if (v1 && req_ready[1]) glog.push_back(1);
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        chk("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
        chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // Present a byte on one requester and hold it until granted
    task automatic send(input int who, input logic [7:0] b);
        bit got;
        got = 1'b0;
        last_wait = 0;
        if (who == 0) begin v0 = 1'b1; d0 = b; end
        else          begin v1 = 1'b1; d1 = b; end
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (req_ready[who]) got = 1'b1;
            else last_wait++;
        end
        chk("send_granted", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        push_cyc = cyc;
        if (who == 0) v0 = 1'b0;
        else          v1 = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic clear_logs();
        pd.delete();
        pc.delete();
        glog.delete();
        peak = 0;
    endtask

    initial begin
        rst_n = 1'b0; tx_en = 1'b0; v0 = 1'b0; v1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
        peak = 0;
        repeat (3) @(negedge clk);
        chk("rst_uart_we", 32'(uart_we), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'h00);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_en = 1'b1;
        @(posedge clk); #1;

        // Single byte
        clear_logs();
        send(0, 8'hA5);
        p0 = push_cyc;
        chk("single_ready_same_cycle", 32'(last_wait), 32'd0);
        wait_cyc(p0 + 8);
        chk("single_idle_busy", 32'(idle), 32'd0);
        wait_cyc(p0 + 9);
        chk("single_idle_back", 32'(idle), 32'd1);
        wait_cyc(p0 + 15);
        chk("single_count", 32'(pd.size()), 32'd1);
        chk("single_data", 32'(pd_at(0)), 32'hA5);
        chk("single_latency", 32'(pc_at(0) - p0), 32'd1);

        // Burst from requester 1
        @(posedge clk); #1;
        clear_logs();
        send(1, 8'h01);
        p0 = push_cyc;
        send(1, 8'h02);
        send(1, 8'h03);
        wait_cyc(p0 + 30);
        chk("burst_count", 32'(pd.size()), 32'd3);
        chk("burst_d0", 32'(pd_at(0)), 32'h01);
        chk("burst_d1", 32'(pd_at(1)), 32'h02);
        chk("burst_d2", 32'(pd_at(2)), 32'h03);
        chk("burst_lat", 32'(pc_at(0) - p0), 32'd1);
        chk("burst_gap1", 32'(pc_at(1) - pc_at(0)), 32'd8);
        chk("burst_gap2", 32'(pc_at(2) - pc_at(1)), 32'd8);
        chk("burst_peak", 32'(peak), 32'd2);

        // Contention between both requesters
        @(posedge clk); #1;
        clear_logs();
        fork
            begin send(0, 8'h10); send(0, 8'h11); end
            begin send(1, 8'h20); send(1, 8'h21); end
        join
        wait_cyc(push_cyc + 40);
        chk("cont_grants", 32'(glog.size()), 32'd4);
        chk("cont_g0", 32'(gl_at(0)), 32'd0);
        chk("cont_g1", 32'(gl_at(1)), 32'd1);
        chk("cont_g2", 32'(gl_at(2)), 32'd0);
        chk("cont_g3", 32'(gl_at(3)), 32'd1);
        chk("cont_d0", 32'(pd_at(0)), 32'h10);
        chk("cont_d1", 32'(pd_at(1)), 32'h20);
        chk("cont_d2", 32'(pd_at(2)), 32'h11);
        chk("cont_d3", 32'(pd_at(3)), 32'h21);

        // Full FIFO backpressure with transmit disabled
        @(posedge clk); #1;
        tx_en = 1'b0;
        clear_logs();
        send(0, 8'h31);
        send(0, 8'h32);
        send(0, 8'h33);
        send(0, 8'h34);
        v0 = 1'b1; d0 = 8'h35;
        repeat (3) @(negedge clk);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_no_pulse", 32'(pd.size()), 32'd0);
        @(posedge clk); #1;
        kc = cyc;
        tx_en = 1'b1;
        send(0, 8'h35);
        chk("full_accept_cycle", 32'(push_cyc), 32'(kc + 2));
        wait_cyc(kc + 50);
        chk("full_first_pulse", 32'(pc_at(0)), 32'(kc + 1));
        chk("full_count", 32'(pd.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("full_order", 32'(pd_at(i)), 32'(8'h31 + i));
        end

        // tx_en cleared mid-WAIT
        @(posedge clk); #1;
        clear_logs();
        send(0, 8'h41);
        p0 = push_cyc;
        send(0, 8'h42);
        send(0, 8'h43);
        @(posedge clk); #1;
        tx_en = 1'b0;
        wait_cyc(p0 + 25);
        chk("hold_count", 32'(pd.size()), 32'd1);
        chk("hold_d0", 32'(pd_at(0)), 32'h41);
        chk("hold_level", 32'(fifo_level), 32'd2);
        chk("hold_idle", 32'(idle), 32'd0);
        @(posedge clk); #1;
        kc = cyc;
        tx_en = 1'b1;
        wait_cyc(kc + 20);
        chk("resume_pulse", 32'(pc_at(1)), 32'(kc + 1));
        chk("resume_d1", 32'(pd_at(1)), 32'h42);
        chk("resume_pulse2", 32'(pc_at(2)), 32'(kc + 9));
        chk("resume_d2", 32'(pd_at(2)), 32'h43);

        // Reset in the middle of traffic
        @(posedge clk); #1;
        clear_logs();
        send(0, 8'h51);
        p0 = push_cyc;
        send(0, 8'h52);
        send(0, 8'h53);
        wait_cyc(p0 + 4);
        chk("mid_pre_pulse", 32'(pd_at(0)), 32'h51);
        @(posedge clk); #1;
        v0 = 1'b1; d0 = 8'h54;
        rst_n = 1'b0;
        clear_logs();
        @(negedge clk);
        chk("mid_rst_we", 32'(uart_we), 32'd0);
        chk("mid_rst_data", 32'(wr_data), 32'h00);
        chk("mid_rst_level", 32'(fifo_level), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        v0 = 1'b0;
        kc = cyc;
        wait_cyc(kc + 30);
        chk("post_rst_no_stale", 32'(pd.size()), 32'd0);
        chk("post_rst_idle", 32'(idle), 32'd1);
        chk("post_rst_level", 32'(fifo_level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
